// File: rtl/pow_token_responder.sv
// Golden start/end token responder: computes x^n mod 2^WIDTH by square-and-multiply,
// one exponent bit per clock, with a single token in flight.
module pow_token_responder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] x_din,
  input  logic [WIDTH-1:0] n_din,
  output logic [WIDTH-1:0] end_out,
  output logic             end_valid,
  input  logic             end_ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_mul, b_sq;

  // The start payload is carried by the protocol but has no meaning here.
  logic unused_start_in;
  assign unused_start_in = start_in;

  assign r_mul = r_q * b_q;
  assign b_sq  = b_q * b_q;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    e_d     = e_q;
    r_d     = r_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          b_d = x_din;
          e_d = n_din;
          r_d = {{(WIDTH-1){1'b0}}, 1'b1};
          if (n_din == '0) begin
            state_d = DONE;
            out_d   = {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (e_q[0]) r_d = r_mul;
        b_d = b_sq;
        e_d = e_q >> 1;
        // end_out is a separate register so it only changes when a result is ready.
        if ((e_q >> 1) == '0) begin
          state_d = DONE;
          out_d   = r_d;
        end
      end
      DONE: begin
        if (end_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      e_q     <= '0;
      r_q     <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      e_q     <= e_d;
      r_q     <= r_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign end_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign end_out     = out_q;
  assign done_count  = cnt_q;

endmodule

// File: tb/tb_pow_token_responder.sv
// Randomized self-checking bench for pow_token_responder against a naive-power model.
module tb_pow_token_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_in = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] x_din = '0;
  logic [31:0] n_din = '0;
  logic [31:0] end_out;
  logic        end_valid;
  logic        end_ready = 1'b0;
  logic        busy;
  logic [15:0] done_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  pow_token_responder #(.WIDTH(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .x_din      (x_din),
    .n_din      (n_din),
    .end_out    (end_out),
    .end_valid  (end_valid),
    .end_ready  (end_ready),
    .busy       (busy),
    .done_count (done_count)
  );

  // Naive repeated multiplication, truncated to 32 bits.
  function automatic logic [31:0] ref_pow(input logic [31:0] x, input logic [31:0] n);
    logic [31:0] r = 32'd1;
    for (longint i = 0; i < longint'(n); i++) r = r * x;
    return r;
  endfunction

  function automatic int ref_lat(input logic [31:0] n);
    int l = 0;
    for (int i = 0; i < 32; i++) if (n[i]) l = i + 1;
    return l;
  endfunction

  // Drives one token and reports what was observed; no checking here.
  task automatic do_token(input logic [31:0] x, input logic [31:0] n, input int hold,
                          output bit acc_rdy, output int lat, output logic [31:0] res,
                          output bit stable);
    @(negedge clk);
    acc_rdy     = start_ready;
    start_valid = 1'b1;
    start_in    = $urandom_range(0, 1);
    x_din       = x;
    n_din       = n;
    end_ready   = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    while (!end_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res    = end_out;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!end_valid || end_out !== res) stable = 1'b0;
    end
    end_ready = 1'b1;
    @(negedge clk);
    end_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({start_ready, end_valid, busy} !== 3'b100) begin
      bad++; $display("FAIL reset_flags got=%b want=100", {start_ready, end_valid, busy});
    end
    total++;
    if (end_out !== 32'd0 || done_count !== 16'd0) begin
      bad++; $display("FAIL reset_data got out=%h cnt=%0d want 0/0", end_out, done_count);
    end
  endtask

  task automatic test_basic();
    bit a; int lat; logic [31:0] res; bit st;
    do_token(32'd2, 32'd3, 0, a, lat, res, st);
    exp_cnt++;
    total++;
    if (!a) begin bad++; $display("FAIL basic_ready got=0 want=1"); end
    total++;
    if (res !== 32'h8) begin bad++; $display("FAIL basic_out got=%h want=00000008", res); end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL basic_lat got=%0d want=2", lat); end
    total++;
    if (done_count !== exp_cnt) begin
      bad++; $display("FAIL basic_cnt got=%0d want=%0d", done_count, exp_cnt);
    end
    total++;
    if ({start_ready, end_valid, busy} !== 3'b100) begin
      bad++; $display("FAIL basic_idle got=%b want=100", {start_ready, end_valid, busy});
    end
  endtask

  task automatic test_zero_exp();
    bit a; int lat; logic [31:0] res; bit st;
    do_token(32'd0, 32'd0, 0, a, lat, res, st);
    exp_cnt++;
    total++;
    if (res !== 32'h1) begin bad++; $display("FAIL zero_out got=%h want=00000001", res); end
    total++;
    if (lat !== 0) begin bad++; $display("FAIL zero_lat got=%0d want=0", lat); end
  endtask

  task automatic test_full_width();
    bit a; int lat; logic [31:0] res; bit st;
    do_token(32'd3, 32'hFFFF_FFFF, 0, a, lat, res, st);
    exp_cnt++;
    total++;
    if (res !== 32'hAAAA_AAAB) begin bad++; $display("FAIL full_out got=%h want=aaaaaaab", res); end
    total++;
    if (lat !== 32) begin bad++; $display("FAIL full_lat got=%0d want=32", lat); end
    do_token(32'd2, 32'd40, 0, a, lat, res, st);
    exp_cnt++;
    total++;
    if (res !== ref_pow(32'd2, 32'd40)) begin
      bad++; $display("FAIL pow2_40 got=%h want=%h", res, ref_pow(32'd2, 32'd40));
    end
    total++;
    if (lat !== 6) begin bad++; $display("FAIL pow2_40_lat got=%0d want=6", lat); end
  endtask

  task automatic test_backpressure();
    bit a; int lat; logic [31:0] res; bit st;
    do_token(32'd5, 32'd2, 6, a, lat, res, st);
    exp_cnt++;
    total++;
    if (res !== 32'h19) begin bad++; $display("FAIL bp_out got=%h want=00000019", res); end
    total++;
    if (!st) begin bad++; $display("FAIL bp_stable got=unstable want=stable"); end
    total++;
    if (start_ready !== 1'b1 || end_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", start_ready, end_valid);
    end
    total++;
    if (done_count !== exp_cnt) begin
      bad++; $display("FAIL bp_cnt got=%0d want=%0d", done_count, exp_cnt);
    end
  endtask

  task automatic test_held_start();
    int vcount = 0;
    @(negedge clk);
    start_valid = 1'b1;
    x_din = 32'd7;
    n_din = 32'd1;
    end_ready = 1'b1;
    @(negedge clk);
    total++;
    if (start_ready !== 1'b0) begin bad++; $display("FAIL held_busy got rdy=%b want=0", start_ready); end
    @(negedge clk);
    start_valid = 1'b0;
    total++;
    if (end_valid !== 1'b1 || end_out !== 32'd7) begin
      bad++; $display("FAIL held_out got vld=%b out=%h want 1/00000007", end_valid, end_out);
    end
    exp_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (end_valid) vcount++;
    end
    end_ready = 1'b0;
    total++;
    if (vcount !== 0 || done_count !== exp_cnt) begin
      bad++; $display("FAIL held_single got extra=%0d cnt=%0d want 0/%0d", vcount, done_count, exp_cnt);
    end
  endtask

  task automatic test_random();
    bit a; int lat; logic [31:0] res; bit st;
    logic [31:0] x, n;
    int errs = 0;
    for (int k = 0; k < 24; k++) begin
      x = $urandom;
      n = $urandom & ((32'd1 << $urandom_range(1, 12)) - 32'd1);
      do_token(x, n, $urandom_range(0, 3), a, lat, res, st);
      exp_cnt++;
      total++;
      if (res !== ref_pow(x, n) || lat !== ref_lat(n) || !st || !a) begin
        bad++;
        $display("FAIL rand_%0d x=%h n=%h got out=%h lat=%0d want out=%h lat=%0d", k, x, n, res,
                 lat, ref_pow(x, n), ref_lat(n));
      end
    end
    total++;
    if (done_count !== exp_cnt) begin
      bad++; $display("FAIL rand_cnt got=%0d want=%0d", done_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit a; int lat; logic [31:0] res; bit st;
    @(negedge clk);
    start_valid = 1'b1;
    x_din = 32'd3;
    n_din = 32'h8000;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({start_ready, end_valid, busy} !== 3'b100 || end_out !== 32'd0 || done_count !== 16'd0)
    begin
      bad++;
      $display("FAIL mid_reset got flags=%b out=%h cnt=%0d want 100/0/0",
               {start_ready, end_valid, busy}, end_out, done_count);
    end
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    do_token(32'd2, 32'd3, 1, a, lat, res, st);
    exp_cnt++;
    total++;
    if (res !== 32'h8 || done_count !== exp_cnt) begin
      bad++; $display("FAIL mid_after got out=%h cnt=%0d want 00000008/%0d", res, done_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_exp();
    test_full_width();
    test_backpressure();
    test_held_start();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pow_token_responder.md
Name: pow_token_responder

Overview:
Hand-written responder for the start/end token protocol that generated dataflow graphs expose. It accepts one start token with operands x and n, computes x^n mod 2^WIDTH by square-and-multiply, and returns one end token. It is the golden responder that graph testbenches can drive in place of a generated graph. It also sits beside a graph in hardware as a cross-check.

Parameters:
WIDTH, 32, data width of x_din, n_din and end_out; all arithmetic is mod 2^WIDTH.
CNT_W, 16, width of the completed-token counter.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
start_in  in  1  start token payload; carried but not interpreted
start_valid  in  1  start token valid
start_ready  out  1  responder can accept a start token
x_din  in  WIDTH  base operand, sampled with the start token
n_din  in  WIDTH  exponent operand, sampled with the start token
end_out  out  WIDTH  result token payload
end_valid  out  1  result token valid
end_ready  in  1  consumer accepts the result token
busy  out  1  high in RUN or DONE
done_count  out  CNT_W  number of end tokens consumed, wraps

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; start_ready=1, end_valid=0, end_out=0, busy=0, done_count=0. All internal registers (b, e, r) are cleared.
- States are IDLE, RUN and DONE. Outputs are registered or decoded from state only. There is no combinational path from start_valid or end_ready to any output.
- IDLE:
  - start_ready=1.
  - Accept happens on the edge where start_valid && start_ready. On accept, latch b=x_din, e=n_din, r=1.
  - Next state is DONE if n_din==0, else RUN.
- RUN (start_ready=0), one exponent bit per edge:
  - if e[0], r <= r*b (low WIDTH bits)
  - b <= b*b (low WIDTH bits)
  - e <= e>>1
  - if (e>>1)==0, next state is DONE.
- Latency: let L = index of the MSB of n plus 1 (L=0 for n=0).
  - end_valid rises after accept edge + L edges.
  - For n=0 it rises on the accept edge itself.
  - Maximum latency is WIDTH edges.
- DONE:
  - end_valid=1 and end_out=r, held stable until end_valid && end_ready.
  - On that edge: go to IDLE, done_count++ (wraps at 2^CNT_W), end_valid deasserts.
  - start_ready returns to 1 in the following cycle.
- Start backpressure: start_valid held for several cycles yields exactly one accept. Later cycles see start_ready=0 and must not be consumed.
- A new start token is accepted only after the previous end token handshakes. At most one token is in flight.
- end_ready high during IDLE or RUN has no effect.
- end_out holds its last value after the handshake until the next DONE.
- Reset mid-RUN or mid-DONE aborts the token: no end_valid, state=IDLE. done_count also clears.
- Result must equal the naive loop (r=1; repeat n: r*=x) truncated to WIDTH bits. In particular 0^0=1.

Test Plan:
- Basic: x=2, n=3, end_ready=1 → end_out=0x00000008; end_valid rises 2 edges after accept; done_count=1.
- Zero exponent: x=0, n=0 → end_out=0x00000001; end_valid asserted right after the accept edge.
- Full-width exponent: x=3, n=0xFFFFFFFF → end_out=0xAAAAAAAB after 32 edges. Also x=2, n=40 → 0x00000000.
- Backpressure: x=5, n=2, end_ready=0 for 6 cycles after end_valid rises → end_valid and end_out=0x19 stay stable; handshake on the first end_ready=1 edge; start_ready=1 on the next cycle.
- Held start: start_valid=1 for 2 consecutive cycles with x=7, n=1 → exactly one accept; single result 0x7; done_count increments by 1.
- Reset mid-op: x=3, n=0x8000, rst=0 during RUN → outputs return to reset values asynchronously. A following x=2, n=3 token still yields 8.
